alu_md_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_md_ctr.sv | 34 +++
 rtl/alu_md_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_md_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Purpose  : Shared definitions for the EX-stage ALU and the multiply/divide
//            sequencer: ALU control codes, the md op encoding and the
//            sequencer FSM state type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  // ALU control codes understood by the shared EX-stage ALU
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_XOR = 4'b1100;

  // op[1] selects divide, op[0] selects signed
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_md_ctr.sv
//------------------------------------------------------------------------------
// Module   : alu_md_ctr
// Purpose  : 5-bit iteration counter for the md sequencer. Counts while
//            i_en is high, sits at zero otherwise; o_last flags count 31.
// Ports    : clk, rst_n (async active-low), i_en (count enable),
//            o_last (terminal count while enabled)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_md_ctr (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_last
);

  logic [4:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd0;
    end else if (!i_en) begin
      r_cnt <= 5'd0;
    end else begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_last = i_en && (r_cnt == 5'd31);

endmodule

`default_nettype wire

// File: rtl/alu_md_seq.sv
//------------------------------------------------------------------------------
// Module   : alu_md_seq
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared
//            32-bit EX-stage ALU (ADD/SUB only) and builds 64-bit HI/LO.
//            Fixed 36-cycle latency from the start edge to done.
// Ports    : clk, rst_n (async active-low); start/op/rs_val/rt_val request;
//            flush abort; alu_req/alu_a/alu_b/alu_ctl drive the ALU and
//            alu_y/alu_cout return its result; busy/stall/done/illegal
//            status; hi/lo results.
// Config   : ALU_MD_DIV_EN - when defined, DIV/DIVU are built; otherwise a
//            divide request pulses illegal and is dropped.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_md_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        alu_req,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctl,
  input  logic [31:0] alu_y,
  input  logic        alu_cout,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        illegal
);

  md_state_t   r_state;
  logic [31:0] r_a;          // rs, then |rs| (multiplicand / dividend)
  logic [31:0] r_b;          // rt, then |rt| (multiplier / divisor)
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_sa;         // signed op with negative rs
  logic        r_sb;         // signed op with negative rt
  logic        r_lo_zero;    // lo was zero before its fix-up (borrow into hi)
  logic        r_busy;
  logic        r_done;
  logic        r_illegal;
  logic        r_alu_req;

  logic        w_last;
  logic        w_fix_lo;
  logic        w_fix_hi_mul;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [3:0]  w_alu_ctl;

`ifdef ALU_MD_DIV_EN
  logic        r_div;
  logic [31:0] w_hi_sh;
  logic        w_qbit;
  logic        w_fix_hi_div;

  // {hi,lo} << 1; r_hi[31] is the shifted-out bit that forces a subtract
  assign w_hi_sh      = {r_hi[30:0], r_lo[31]};
  assign w_qbit       = r_hi[31] | alu_cout;
  assign w_fix_hi_div = r_div & r_sa;
  assign w_fix_hi_mul = ~r_div & (r_sa ^ r_sb);
`else
  assign w_fix_hi_mul = r_sa ^ r_sb;
`endif

  // Quotient and product both flip sign when operand signs differ
  assign w_fix_lo = r_sa ^ r_sb;

  alu_md_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == S_ITER),
    .o_last (w_last)
  );

  // ALU operand/control decode; depends only on registered state
  always_comb begin
    w_alu_a   = 32'd0;
    w_alu_b   = 32'd0;
    w_alu_ctl = C_ALU_ADD;
    case (r_state)
      S_NEG_A: begin
        if (r_sa) begin
          w_alu_b   = r_a;
          w_alu_ctl = C_ALU_SUB;
        end else begin
          w_alu_a = r_a;
        end
      end
      S_NEG_B: begin
        if (r_sb) begin
          w_alu_b   = r_b;
          w_alu_ctl = C_ALU_SUB;
        end else begin
          w_alu_a = r_b;
        end
      end
      S_ITER: begin
`ifdef ALU_MD_DIV_EN
        if (r_div) begin
          w_alu_a   = w_hi_sh;
          w_alu_b   = r_b;
          w_alu_ctl = C_ALU_SUB;
        end else
`endif
        begin
          w_alu_a = r_hi;
          w_alu_b = r_lo[0] ? r_a : 32'd0;
        end
      end
      S_FIX_LO: begin
        if (w_fix_lo) begin
          w_alu_b   = r_lo;
          w_alu_ctl = C_ALU_SUB;
        end else begin
          w_alu_a = r_lo;
        end
      end
      S_FIX_HI: begin
        if (w_fix_hi_mul) begin
          // two's-complement negate of the 64-bit product, upper half
          w_alu_a = ~r_hi;
          w_alu_b = {31'd0, r_lo_zero};
`ifdef ALU_MD_DIV_EN
        end else if (w_fix_hi_div) begin
          w_alu_b   = r_hi;
          w_alu_ctl = C_ALU_SUB;
`endif
        end else begin
          w_alu_a = r_hi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_lo_zero <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_alu_req <= 1'b0;
`ifdef ALU_MD_DIV_EN
      r_div     <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (flush && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_alu_req <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !flush) begin
`ifndef ALU_MD_DIV_EN
              if (op[1]) begin
                r_illegal <= 1'b1;
              end else
`endif
              begin
                r_state   <= S_NEG_A;
                r_busy    <= 1'b1;
                r_alu_req <= 1'b1;
                r_a       <= rs_val;
                r_b       <= rt_val;
                r_sa      <= op[0] & rs_val[31];
                r_sb      <= op[0] & rt_val[31];
`ifdef ALU_MD_DIV_EN
                r_div     <= op[1];
`endif
              end
            end
          end
          S_NEG_A: begin
            r_a     <= alu_y;
            r_state <= S_NEG_B;
          end
          S_NEG_B: begin
            // multiply: lo holds the multiplier; divide: lo holds the dividend
            r_b  <= alu_y;
            r_hi <= 32'd0;
`ifdef ALU_MD_DIV_EN
            r_lo <= r_div ? r_a : alu_y;
`else
            r_lo <= alu_y;
`endif
            r_state <= S_ITER;
          end
          S_ITER: begin
`ifdef ALU_MD_DIV_EN
            if (r_div) begin
              r_hi <= w_qbit ? alu_y : w_hi_sh;
              r_lo <= {r_lo[30:0], w_qbit};
            end else
`endif
            begin
              r_hi <= {alu_cout, alu_y[31:1]};
              r_lo <= {alu_y[0], r_lo[31:1]};
            end
            if (w_last) begin
              r_state <= S_FIX_LO;
            end
          end
          S_FIX_LO: begin
            r_lo_zero <= (r_lo == 32'd0);
            r_lo      <= alu_y;
            r_state   <= S_FIX_HI;
          end
          S_FIX_HI: begin
            r_hi      <= alu_y;
            r_done    <= 1'b1;
            r_alu_req <= 1'b0;
            r_state   <= S_DONE;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy    <= 1'b0;
            r_alu_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign alu_req = r_alu_req;
  assign alu_a   = w_alu_a;
  assign alu_b   = w_alu_b;
  assign alu_ctl = w_alu_ctl;
  assign busy    = r_busy;
  assign stall   = r_busy;
  assign done    = r_done;
  assign illegal = r_illegal;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_md_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_md_seq
// Purpose  : Self-checking bench for alu_md_seq with a behavioural ALU and a
//            scoreboard of expected {hi,lo} results. Divide expectations
//            follow ALU_MD_DIV_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_md_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_y;
  logic        alu_cout;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        illegal;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_exp = 64'd0;

  always #5 clk = ~clk;

  alu_md_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .alu_req  (alu_req),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctl  (alu_ctl),
    .alu_y    (alu_y),
    .alu_cout (alu_cout),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .illegal  (illegal)
  );

  // Behavioural shared ALU (ADD/SUB only)
  logic [32:0] w_sum;
  always_comb begin
    w_sum = 33'd0;
    case (alu_ctl)
      C_ALU_ADD: w_sum = {1'b0, alu_a} + {1'b0, alu_b};
      C_ALU_SUB: w_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default:   w_sum = 33'd0;
    endcase
  end
  assign alu_y    = w_sum[31:0];
  assign alu_cout = w_sum[32];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference result {hi,lo}; signed divide truncates toward zero
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic        sa, sb;
    p = 64'd0;
    case (o)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      default: begin
        sa = o[0] & a[31];
        sb = o[0] & b[31];
        ma = sa ? (32'd0 - a) : a;
        mb = sb ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        if (sa ^ sb) q = 32'd0 - q;
        if (sa) r = 32'd0 - r;
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {59'd0, busy, stall, done, illegal, alu_req}, 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, 64'd0);
    chk({tag, "_alu"}, {alu_a, alu_b}, 64'd0);
    chk({tag, "_aluctl"}, {60'd0, alu_ctl}, {60'd0, C_ALU_ADD});
  endtask

  // Issue one op, push its expectation, then pop and compare at done.
  // poke > 0 re-asserts start with other operands at that cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int poke);
    int          cyc;
    bit          busy_ok;
    logic [63:0] e;
    sb_q.push_back(exp);
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; rs_val = ~a; rt_val = ~b;
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && !(busy && stall && alu_req)) busy_ok = 1'b0;
      start = (cyc == poke) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'd36);
    chk({tag, "_stall"}, {63'd0, busy_ok}, 64'd1);
    e = sb_q.pop_front();
    chk({tag, "_hilo"}, {hi, lo}, e);
    last_exp = e;
    @(posedge clk);
    #1;
    chk({tag, "_after"}, {60'd0, done, busy, stall, alu_req}, 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    run_op("mult_poke", 2'b00, 32'd1000, 32'd3000, 64'd3000000, 5);

`ifdef ALU_MD_DIV_EN
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0);
    run_op("div_poke", 2'b11, 32'd77, 32'hFFFF_FFF6, {32'd7, 32'hFFFF_FFF9}, 20);
`else
    // Divide request rejected: one-cycle illegal, no busy, results untouched
    @(negedge clk);
    op = 2'b10; rs_val = 32'd5; rt_val = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    chk("illegal_pulse", {62'd0, illegal, busy}, 64'd2);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("illegal_end", {62'd0, illegal, busy}, 64'd0);
    chk("illegal_hilo", {hi, lo}, last_exp);
`endif

    for (int i = 0; i < 6; i++) begin
`ifdef ALU_MD_DIV_EN
      ro = 2'($urandom_range(0, 3));
`else
      ro = 2'($urandom_range(0, 1));
`endif
      ra = $urandom;
      rb = (i == 0) ? 32'd3 : $urandom;
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), 0);
    end

    // flush while ITER count is 10
    @(negedge clk);
    op = 2'b00; rs_val = 32'h1234; rt_val = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_idle", {61'd0, busy, stall, alu_req}, 64'd0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done || busy) saw_done = 1'b1;
      end
      chk("flush_nodone", {63'd0, saw_done}, 64'd0);
    end

    // flush together with start in IDLE
    @(negedge clk);
    op = 2'b00; rs_val = 32'd2; rt_val = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_start", {62'd0, busy, alu_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;

    // asynchronous reset during ITER
    @(negedge clk);
    op = 2'b00; rs_val = 32'hDEAD; rt_val = 32'hBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_3x4", 2'b00, 32'd3, 32'd4, 64'd12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
